// File: rtl/sram_rw_arbiter.sv
// Single-port arbiter for a 4x786 masked-write SRAM macro: write/read requesters share RW0,
// read data lands in a 2-entry response FIFO so the consumer may stall.
module sram_rw_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 786,
  parameter int MASK_W = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic              rd_inflight;
  logic [1:0]        resp_cnt;
  logic              wptr;
  logic              rptr;
  logic              prio;
  logic [DATA_W-1:0] fifo_mem [2];

  logic              pop;
  logic              push;
  logic [2:0]        occ;
  logic              rd_ok;
  logic              rd_req;
  logic              conflict;
  logic              gnt_wr;
  logic              gnt_rd;

  // Stage p0: grant decision. Occupancy counts the read already on the macro so the FIFO can never overflow.
  always_comb begin
    pop      = resp_valid && resp_ready;
    push     = rd_inflight;
    occ      = {1'b0, resp_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    rd_ok    = occ < 3'd2;
    rd_req   = rd_valid && rd_ok;
    conflict = wr_valid && rd_req;
    gnt_wr   = reset_n && wr_valid && (!rd_req || prio);
    gnt_rd   = reset_n && rd_req && !(wr_valid && prio);
  end

  assign wr_ready   = gnt_wr;
  assign rd_ready   = gnt_rd;
  assign resp_valid = resp_cnt != 2'd0;
  assign resp_data  = resp_valid ? fifo_mem[rptr] : '0;

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (gnt_wr) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = wr_addr;
      sram_wmask = wr_mask;
      sram_wdata = wr_data;
    end else if (gnt_rd) begin
      sram_en    = 1'b1;
      sram_addr  = rd_addr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_inflight <= 1'b0;
      resp_cnt    <= 2'd0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      prio        <= 1'b0;
    end else begin
      rd_inflight <= gnt_rd;
      if (conflict) prio <= ~prio;
      if (push)     wptr <= ~wptr;
      if (pop)      rptr <= ~rptr;
      case ({push, pop})
        2'b10:   resp_cnt <= resp_cnt + 2'd1;
        2'b01:   resp_cnt <= resp_cnt - 2'd1;
        default: resp_cnt <= resp_cnt;
      endcase
    end
  end

  // Stage p1: macro read data is valid the cycle after the grant and is captured here.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wptr] <= sram_rdata;
  end

endmodule

// File: doc/sram_rw_arbiter.md
# sram_rw_arbiter

Single-port SRAM access controller for the 4-entry × 786-bit masked-write array macros (six 131-bit write-mask lanes, one-cycle registered read).

- Shares the macro's one RW port between a write requester (fill/update path) and a read requester (lookup path).
- Drives the macro's `RW0_*` pins from the grant each cycle.
- Captures read data the cycle it is valid into a 2-entry response FIFO, so the consumer can stall without losing data.

## Interface
Parameters:
- `ADDR_W`, default 2: array address width (4 entries).
- `DATA_W`, default 786: array word width.
- `MASK_W`, default 6: write-mask lanes; lane i covers bits [i*DATA_W/MASK_W +: DATA_W/MASK_W].

Ports (all active-high except reset):
- `clock`  in  1  sole clock; also drives the macro's `RW0_clk`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write granted this cycle (accepted when `wr_valid && wr_ready`).
- `wr_addr`  in  ADDR_W  write address.
- `wr_mask`  in  MASK_W  write lane enables.
- `wr_data`  in  DATA_W  write data.
- `rd_valid`  in  1  read request.
- `rd_ready`  out  1  read granted this cycle.
- `rd_addr`  in  ADDR_W  read address.
- `resp_valid`  out  1  read data available at FIFO head.
- `resp_ready`  in  1  consumer pops head.
- `resp_data`  out  DATA_W  FIFO head data.
- `sram_en`, `sram_wmode`  out  1 each  to `RW0_en`, `RW0_wmode`.
- `sram_addr`  out  ADDR_W  to `RW0_addr`.
- `sram_wmask`  out  MASK_W  to `RW0_wmask`.
- `sram_wdata`  out  DATA_W  to `RW0_wdata`.
- `sram_rdata`  in  DATA_W  from `RW0_rdata`.

## Operation
State:
- `rd_inflight` (1b): a read was issued last cycle.
- `resp_cnt` (0..2), with 2-entry FIFO storage and read/write pointers.
- `prio` (1b): 0 = read preferred, 1 = write preferred.

Read eligibility:
- `pop = resp_valid && resp_ready`.
- `rd_ok = (resp_cnt + rd_inflight - pop) < 2`.
- Computed in 3-bit arithmetic, so the subtraction never wraps.

Grant, combinational, exactly one or none per cycle:
- Only `wr_valid`: grant write.
- Only `rd_valid && rd_ok`: grant read.
- `rd_valid` with `!rd_ok`: read not granted; write granted if valid; `prio` unchanged.
- Both `wr_valid` and `rd_valid && rd_ok` (conflict): grant write if `prio` = 1, else grant read.
- On a conflict, `prio` takes the value that favours the loser next cycle. `prio` changes only on conflicts.
- `wr_ready` = write granted; `rd_ready` = read granted. Neither depends on its own valid beyond the grant rule.

Macro drive:
- Write grant: `sram_en`=1, `sram_wmode`=1, addr/mask/data = `wr_*`.
- Read grant: `sram_en`=1, `sram_wmode`=0, `sram_addr` = `rd_addr`, `sram_wmask` = 0, `sram_wdata` = 0.
- No grant: `sram_en`=0; all other macro outputs 0.

Write details:
- A write with `wr_mask` = 0 is still granted and issued; the array contents are unchanged.

Read response:
- `rd_inflight <= read granted`.
- When `rd_inflight` = 1, `sram_rdata` is pushed into the FIFO at that clock edge.
- Push and pop in the same cycle are both performed; `resp_cnt` is unchanged.
- Responses are returned in issue order.
- Overflow is impossible by construction. The bench asserts `resp_cnt` ≤ 2 and no push while full without a pop.

Ordering:
- All accesses are serialized through the single port.
- A read granted in a later cycle than a write to the same address returns the written data.
- There is no same-cycle read/write (only one grant per cycle).

## Timing
Reset:
- `reset_n` low asynchronously clears `rd_inflight`, `resp_cnt`, and the FIFO pointers, and sets `prio` = 0.
- While in reset, all outputs are 0: `wr_ready`, `rd_ready`, `resp_valid`, `sram_*`.
- FIFO data contents are not reset; `resp_data` is 0 whenever `resp_valid` = 0.
- Reset mid-operation drops any in-flight read and all buffered responses.
- The first grant can occur in the first cycle after `reset_n` deasserts.

Read latency:
- Grant at cycle t, macro data valid at t+1, push at end of t+1, `resp_valid` high at t+2 (2 cycles from grant to response).

Throughput:
- With `resp_ready` held high, one read per cycle sustained.
- With `resp_ready` low, at most 2 reads outstanding. The third read is held off (`rd_ready` = 0) until a pop.

Write latency:
- Array updated at the end of the grant cycle.

## Test plan
- Reset, then read addr 0 at cycle 1: `rd_ready`=1 at 1, `resp_valid`=1 at 3.
- Write addr 2, mask 6'b111111, data all-ones; next cycle read addr 2: response equals all-ones. Repeat with mask 6'b000001 and data 0: only bits [130:0] become 0.
- Hold both `wr_valid` and `rd_valid` for 6 cycles with `resp_ready`=1: grants alternate R,W,R,W,R,W starting with read.
- `resp_ready`=0, read issued every cycle: exactly 2 reads granted, `rd_ready` stays 0. A concurrent `wr_valid` is granted every cycle. Raising `resp_ready` pops 2 in order, then reads resume.
- Write valid alone with `wr_mask`=0: `sram_en`=1, `wr_ready`=1; a later read shows data unchanged.
- Assert `reset_n`=0 one cycle after a read grant with 1 entry buffered: `resp_valid` and `sram_en` drop to 0 immediately. After release there is no stale response and `prio`=0.
